// File: rtl/train_sched.sv
// Epoch/sample scheduler: issues TR/VL pulses to the phase sequencer and tracks sample/epoch indices.
// Optional feature: define SCHED_VAL_EN to run a validation pass after each epoch's training pass.
module train_sched #(
  parameter int SAMPLE_W = 8,
  parameter int EPOCH_W  = 8,
  parameter int START_TO = 2,
  parameter int PASS_TO  = 127
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [SAMPLE_W-1:0] n_train,
  input  logic [SAMPLE_W-1:0] n_val,
  input  logic [EPOCH_W-1:0]  n_epoch,
  input  logic                FPH,
  input  logic                FPO,
  input  logic                BPH,
  input  logic                BPO,
  output logic                TR,
  output logic                VL,
  output logic [SAMPLE_W-1:0] addr,
  output logic [EPOCH_W-1:0]  epoch,
  output logic                busy,
  output logic                done,
  output logic                err
);

`ifdef SCHED_VAL_EN
  localparam bit VAL_EN = 1'b1;
`else
  localparam bit VAL_EN = 1'b0;
`endif

  localparam int TMAX = (START_TO > PASS_TO) ? START_TO : PASS_TO;
  localparam int TW = $clog2(TMAX + 2);
  localparam logic [TW-1:0] START_LIM = TW'(START_TO - 1);
  localparam logic [TW-1:0] PASS_LIM  = TW'(PASS_TO);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_END, NEXT, FIN} state_t;

  state_t              state, state_nx;
  logic [SAMPLE_W-1:0] nt_q, nv_q;
  logic [EPOCH_W-1:0]  ne_q;
  logic                val_pass;
  logic [TW-1:0]       cnt;

  logic act, run_empty, last_train, last_val, last_epoch, pass_end, to_val, timeout;

  // cnt counts idle cycles in WAIT_START and high cycles of act in WAIT_END
  assign act        = FPH | FPO | BPH | BPO;
  assign run_empty  = (n_epoch == '0) || ((n_train == '0) && !(VAL_EN && (n_val != '0)));
  assign last_train = (addr == nt_q - SAMPLE_W'(1));
  assign last_val   = (addr == nv_q - SAMPLE_W'(1));
  assign last_epoch = (epoch == ne_q - EPOCH_W'(1));
  assign pass_end   = val_pass ? last_val : last_train;
  assign to_val     = !val_pass && VAL_EN && (nv_q != '0);
  assign timeout    = ((state == WAIT_START) && !act && (cnt == START_LIM)) ||
                      ((state == WAIT_END)   &&  act && (cnt == PASS_LIM));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (start) state_nx = run_empty ? FIN : ISSUE;
      ISSUE:      if (!act) state_nx = WAIT_START;
      WAIT_START: if (act) state_nx = WAIT_END;
                  else if (timeout) state_nx = IDLE;
      WAIT_END:   if (!act) state_nx = NEXT;
                  else if (timeout) state_nx = IDLE;
      NEXT:       state_nx = (pass_end && !to_val && last_epoch) ? FIN : ISSUE;
      FIN:        state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    TR   = 1'b0;
    VL   = 1'b0;
    busy = (state == ISSUE) || (state == WAIT_START) || (state == WAIT_END) || (state == NEXT);
    done = (state == FIN);
    if ((state == ISSUE) && !act) begin
      TR = !val_pass;
`ifdef SCHED_VAL_EN
      VL = val_pass;
`else
      VL = 1'b0;
`endif
    end
  end

  // A zero-length training pass is skipped by starting each epoch directly in validation
  always_ff @(posedge clk) begin
    if (rst) begin
      nt_q     <= '0;
      nv_q     <= '0;
      ne_q     <= '0;
      val_pass <= 1'b0;
      cnt      <= '0;
      addr     <= '0;
      epoch    <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          nt_q     <= n_train;
          nv_q     <= n_val;
          ne_q     <= n_epoch;
          val_pass <= (n_train == '0);
          cnt      <= '0;
          addr     <= '0;
          epoch    <= '0;
          err      <= 1'b0;
        end
        ISSUE: cnt <= '0;
        WAIT_START: begin
          cnt <= act ? TW'(1) : cnt + TW'(1);
          if (timeout) err <= 1'b1;
        end
        WAIT_END: begin
          if (act) cnt <= cnt + TW'(1);
          if (timeout) err <= 1'b1;
        end
        NEXT: begin
          if (!pass_end) begin
            addr <= addr + SAMPLE_W'(1);
          end else begin
            addr <= '0;
            if (to_val) begin
              val_pass <= 1'b1;
            end else begin
              val_pass <= (nt_q == '0);
              if (!last_epoch) epoch <= epoch + EPOCH_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_train_sched.sv
// Self-checking bench for train_sched: vector table plus hand sequences, with a pulse scoreboard
// fed by an independent loop model and a small phase-sequencer model driving the phase lines.
module tb_train_sched;

`ifdef SCHED_VAL_EN
  localparam bit VALON = 1'b1;
`else
  localparam bit VALON = 1'b0;
`endif
  localparam int START_TO = 2;
  localparam int PASS_TO  = 127;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] n_train = '0, n_val = '0, n_epoch = '0;
  logic       FPH, FPO, BPH, BPO;
  logic       TR, VL, busy, done, err;
  logic [7:0] addr, epoch;

  typedef struct packed { logic vl; logic [7:0] addr; logic [7:0] epoch; } pulse_t;
  typedef struct { int nt; int nv; int ne; int p_on; int p_off; } vec_t;

  pulse_t exp_q[$];
  int     total = 0, bad = 0;
  int     pulse_cnt = 0, done_cnt = 0;
  int     seq_mode = 0;
  logic   hold = 1'b0;
  int     act_cnt = 0;

  train_sched dut (
    .clk(clk), .rst(rst), .start(start), .n_train(n_train), .n_val(n_val), .n_epoch(n_epoch),
    .FPH(FPH), .FPO(FPO), .BPH(BPH), .BPO(BPO), .TR(TR), .VL(VL), .addr(addr), .epoch(epoch),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Sequencer model: mode 0 normal, 1 never answers, 2 sticks with FPH high
  always @(posedge clk) begin
    if (rst) act_cnt <= 0;
    else if ((TR || VL) && seq_mode != 1) act_cnt <= 4;
    else if (act_cnt != 0 && seq_mode != 2) act_cnt <= act_cnt - 1;
  end
  assign FPH = (act_cnt == 4);
  assign FPO = (act_cnt == 3);
  assign BPH = (act_cnt == 2);
  assign BPO = (act_cnt == 1) || hold;

  task automatic checkOutput(input string name, input int actual, input int required);
    total++;
    if (actual != required) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  // Every pulse is matched against the next expected {TR,VL,addr,epoch}
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (TR || VL) begin
        pulse_t e;
        pulse_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL pulse_unexpected: got TR=%0d VL=%0d addr=%0d epoch=%0d, required no pulse",
                   TR, VL, addr, epoch);
        end else begin
          e = exp_q.pop_front();
          if ({TR, VL, addr, epoch} !== {~e.vl, e.vl, e.addr, e.epoch}) begin
            bad++;
            $display("[TB] FAIL pulse_fields: got TR=%0d VL=%0d addr=%0d epoch=%0d, required TR=%0d VL=%0d addr=%0d epoch=%0d",
                     TR, VL, addr, epoch, ~e.vl, e.vl, e.addr, e.epoch);
          end
        end
      end
    end
  end

  task automatic pushModel(input int nt, input int nv, input int ne);
    for (int e = 0; e < ne; e++) begin
      for (int a = 0; a < nt; a++) exp_q.push_back({1'b0, 8'(a), 8'(e)});
      if (VALON) for (int a = 0; a < nv; a++) exp_q.push_back({1'b1, 8'(a), 8'(e)});
    end
  endtask

  // Leaves the caller at the negedge of cycle 1 (the cycle after start is sampled)
  task automatic applyStimulus(input int nt, input int nv, input int ne, input bit use_model);
    if (use_model) pushModel(nt, nv, ne);
    pulse_cnt = 0;
    done_cnt  = 0;
    n_train = 8'(nt);
    n_val   = 8'(nv);
    n_epoch = 8'(ne);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finishRun(input string name, input int exp_pulses, input int exp_epoch);
    bit seen = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checkOutput({name, "_done_seen"}, seen, 1);
    checkOutput({name, "_busy_at_done"}, busy, 0);
    checkOutput({name, "_epoch_final"}, epoch, exp_epoch);
    checkOutput({name, "_err"}, err, 0);
    repeat (2) @(negedge clk);
    checkOutput({name, "_done_count"}, done_cnt, 1);
    checkOutput({name, "_pulse_count"}, pulse_cnt, exp_pulses);
    checkOutput({name, "_queue_left"}, exp_q.size(), 0);
  endtask

  function automatic int expEpoch(input int nt, input int nv, input int ne);
    if (ne == 0 || (nt == 0 && !(VALON && nv != 0))) return 0;
    return ne - 1;
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    bit   reached;
    int   per_epoch;
    vecs[0] = '{2, 1, 1, 3, 2};
    vecs[1] = '{3, 2, 2, 10, 6};
    vecs[2] = '{1, 5, 3, 18, 3};
    vecs[3] = '{0, 2, 2, 4, 0};
    vecs[4] = '{0, 0, 3, 0, 0};
    vecs[5] = '{4, 0, 1, 4, 4};
    vecs[6] = '{1, 1, 0, 0, 0};

    repeat (2) @(negedge clk);
    checkOutput("reset_TR", TR, 0);
    checkOutput("reset_VL", VL, 0);
    checkOutput("reset_addr", addr, 0);
    checkOutput("reset_epoch", epoch, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_err", err, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      int np;
      np = VALON ? vecs[i].p_on : vecs[i].p_off;
      applyStimulus(vecs[i].nt, vecs[i].nv, vecs[i].ne, 1'b1);
      checkOutput($sformatf("vec%0d_first_pulse", i), TR || VL, np != 0);
      checkOutput($sformatf("vec%0d_first_addr", i), addr, 0);
      finishRun($sformatf("vec%0d", i), np, expEpoch(vecs[i].nt, vecs[i].nv, vecs[i].ne));
    end

    // Zero epochs: done in the cycle right after start, busy already low
    applyStimulus(1, 1, 0, 1'b1);
    checkOutput("zero_epoch_done_cycle1", done, 1);
    checkOutput("zero_epoch_busy_cycle1", busy, 0);
    repeat (3) @(negedge clk);
    checkOutput("zero_epoch_done_count", done_cnt, 1);

    // Silent sequencer: err and busy fall START_TO+1 cycles after the TR
    seq_mode = 1;
    exp_q.push_back({1'b0, 8'd0, 8'd0});
    applyStimulus(2, 0, 1, 1'b0);
    checkOutput("start_to_tr", TR, 1);
    repeat (START_TO) @(negedge clk);
    checkOutput("start_to_err_early", err, 0);
    checkOutput("start_to_busy_early", busy, 1);
    @(negedge clk);
    checkOutput("start_to_err", err, 1);
    checkOutput("start_to_busy", busy, 0);
    repeat (10) @(negedge clk);
    checkOutput("start_to_pulses", pulse_cnt, 1);
    checkOutput("start_to_no_done", done_cnt, 0);
    checkOutput("start_to_err_sticky", err, 1);
    seq_mode = 0;

    // Stuck FPH: err after PASS_TO+1 cycles of act, next start clears it
    seq_mode = 2;
    exp_q.push_back({1'b0, 8'd0, 8'd0});
    applyStimulus(2, 0, 1, 1'b0);
    repeat (PASS_TO + 1) @(negedge clk);
    checkOutput("pass_to_err_early", err, 0);
    checkOutput("pass_to_busy_early", busy, 1);
    @(negedge clk);
    checkOutput("pass_to_err", err, 1);
    checkOutput("pass_to_busy", busy, 0);
    seq_mode = 0;
    repeat (8) @(negedge clk);
    checkOutput("pass_to_pulses", pulse_cnt, 1);
    applyStimulus(1, 0, 1, 1'b1);
    checkOutput("restart_err_cleared", err, 0);
    finishRun("restart", 1, 0);

    // Phase lines still high at issue time hold back the pulse
    hold = 1'b1;
    applyStimulus(1, 0, 1, 1'b1);
    checkOutput("hold_no_tr", TR, 0);
    checkOutput("hold_busy", busy, 1);
    @(posedge clk);
    #1 hold = 1'b0;
    @(negedge clk);
    checkOutput("hold_release_tr", TR, 1);
    finishRun("hold", 1, 0);

    // Reset in the middle of the second epoch, then a clean restart
    per_epoch = VALON ? 4 : 3;
    applyStimulus(3, 1, 2, 1'b1);
    reached = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (pulse_cnt == per_epoch + 2) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    checkOutput("midrst_reached", reached, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_TR", TR, 0);
    checkOutput("midrst_VL", VL, 0);
    checkOutput("midrst_addr", addr, 0);
    checkOutput("midrst_epoch", epoch, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_err", err, 0);
    rst = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    applyStimulus(3, 1, 2, 1'b1);
    checkOutput("midrst_restart_tr", TR, 1);
    finishRun("midrst_restart", VALON ? 8 : 6, 1);

    // A start pulse with different counts while busy changes nothing
    applyStimulus(1, 5, 3, 1'b1);
    repeat (5) @(negedge clk);
    n_train = 8'd7;
    n_val   = 8'd2;
    n_epoch = 8'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finishRun("busy_start", VALON ? 18 : 3, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
